// File: rtl/rvcpu_mem_pkg.sv
// rvcpu_mem_pkg
//  Shared definitions for CPU data-memory responders:
//   - dm_rd_ctrl / dm_wr_ctrl encodings (0 = no access)
//   - UART TX register indices, as decoded from dm_addr[4:3]
//   - STATUS bit positions
//   - serializer FSM state enum
//   - eff_div(): maps a BAUDDIV value to the bit period actually used
//  No ports (package).
package rvcpu_mem_pkg;

    // Load types on dm_rd_ctrl
    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_LB   = 3'd1;
    localparam logic [2:0] LD_LH   = 3'd2;
    localparam logic [2:0] LD_LW   = 3'd3;
    localparam logic [2:0] LD_LD   = 3'd4;
    localparam logic [2:0] LD_LBU  = 3'd5;
    localparam logic [2:0] LD_LHU  = 3'd6;
    localparam logic [2:0] LD_LWU  = 3'd7;

    // Store types on dm_wr_ctrl
    localparam logic [2:0] ST_NONE = 3'd0;
    localparam logic [2:0] ST_SB   = 3'd1;
    localparam logic [2:0] ST_SH   = 3'd2;
    localparam logic [2:0] ST_SW   = 3'd3;
    localparam logic [2:0] ST_SD   = 3'd4;

    // UART register indices (byte offsets 0x00, 0x08, 0x10, 0x18)
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam logic [1:0] REG_RSVD    = 2'd3;

    // STATUS bit positions; fifo count occupies [15:8]
    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_PAR     = 4;
    localparam int STAT_CNT_LSB = 8;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    // A programmed divider of 0 would mean a zero-length bit; run it as 1.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// tx_fifo
//  Synchronous first-word-fall-through FIFO with binary pointers.
//  DEPTH must be a power of two so the pointers wrap naturally.
//  Ports:
//   clk, rst_n   clock, asynchronous active-low reset (empties the FIFO)
//   push, din    write request / data; ignored while full
//   pop          read request; ignored while empty
//   dout         head entry, valid whenever empty=0
//   full, empty  occupancy flags
//   count        number of entries, $clog2(DEPTH)+1 bits
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    // Push and pop are independent; both in one cycle keeps the count.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted in.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio
//  Memory-mapped 8N1 UART transmitter on the CPU data-memory bus.
//  Register window of 32 bytes at BASE_ADDR, decoded on dm_addr[4:3]:
//   0x00 TXDATA  (W)    push dm_din[7:0]; dropped and overflow set if full
//   0x08 STATUS  (R/W1C) [0] busy [1] full [2] empty [3] overflow
//                        [4] parity enabled [15:8] fifo count
//   0x10 BAUDDIV (R/W)  clk cycles per bit, 0 runs as 1
//   0x18 reserved       reads 0, writes ignored
//  Build option: define UART_PARITY_EN to append an even parity bit
//  after the data bits (11-bit frames, STATUS[4]=1).
//  Ports:
//   clk, rst            clock, asynchronous active-low reset
//   dm_rd_ctrl          load type (loads are side-effect free, type ignored)
//   dm_wr_ctrl          store type, nonzero = store
//   dm_addr, dm_din     byte address, store data
//   dm_dout             load data, combinational, 0 when hit=0
//   hit                 dm_addr falls inside the register window
//   txd                 serial output, idle high
//   irq_empty           FIFO empty and serializer idle
//   dbg_state           serializer FSM state
//
//  Bus handshake: there is no valid/ready back-pressure. A store commits
//  on the clock edge where hit && dm_wr_ctrl != 0 and is always accepted
//  in that cycle; a load is a pure combinational read of the selected
//  register while hit=1. Internally the serializer pops the FIFO only
//  when it is non-empty, and the register file pushes only when not full.
module uart_tx_mmio
    import rvcpu_mem_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_1000_0000,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  dm_rd_ctrl,
    input  logic [2:0]  dm_wr_ctrl,
    input  logic [63:0] dm_addr,
    input  logic [63:0] dm_din,
    output logic [63:0] dm_dout,
    output logic        hit,
    output logic        txd,
    output logic        irq_empty,
    output logic [2:0]  dbg_state
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

`ifdef UART_PARITY_EN
    localparam tx_state_e AFTER_DATA = TX_PARITY;
    localparam logic      PARITY_EN  = 1'b1;
`else
    localparam tx_state_e AFTER_DATA = TX_STOP;
    localparam logic      PARITY_EN  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [1:0] reg_sel;
    logic       wr_en;
    logic       unused_bits;

    assign hit     = (dm_addr[63:5] == BASE_ADDR[63:5]);
    assign reg_sel = dm_addr[4:3];
    assign wr_en   = hit && (dm_wr_ctrl != ST_NONE);

    // Load type, byte offset and upper store data carry no meaning here.
    assign unused_bits = ^{dm_rd_ctrl, dm_addr[2:0], dm_din[63:16]};

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic          fifo_push, fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;

    tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (dm_din[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [15:0] baud_div_q, baud_div_d;
    logic        ovf_q, ovf_d;

    always_comb begin
        baud_div_d = baud_div_q;
        ovf_d      = ovf_q;
        fifo_push  = 1'b0;
        if (wr_en && (reg_sel == REG_STATUS) && dm_din[STAT_OVF]) begin
            ovf_d = 1'b0;
        end
        // Evaluated after the clear so an overflowing push wins.
        if (wr_en && (reg_sel == REG_TXDATA)) begin
            if (fifo_full) ovf_d     = 1'b1;
            else           fifo_push = 1'b1;
        end
        if (wr_en && (reg_sel == REG_BAUDDIV)) begin
            baud_div_d = dm_din[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_div_q <= DIV_RESET;
            ovf_q      <= 1'b0;
        end else begin
            baud_div_q <= baud_div_d;
            ovf_q      <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM and baud counter
    // ------------------------------------------------------------------
    tx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] bit_div_q, bit_div_d;   // period latched for the current bit
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic        txd_q, txd_d;
    logic        busy_q, busy_d;
    logic        bit_end;
    logic        busy;

    assign bit_end = (cnt_q == (bit_div_q - 16'd1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= TX_IDLE;
        else      state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = TX_START;
                end
            end
            TX_START: begin
                if (bit_end) state_d = TX_DATA;
            end
            TX_DATA: begin
                if (bit_end && (bit_idx_q == 3'd7)) state_d = AFTER_DATA;
            end
            TX_PARITY: begin
                if (bit_end) state_d = TX_STOP;
            end
            TX_STOP: begin
                // Back-to-back frames: skip IDLE when another byte waits.
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = TX_START;
                    end else begin
                        state_d  = TX_IDLE;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Bit timing and shift register. BAUDDIV is sampled only at bit
    // boundaries, so a rewrite never stretches or cuts the current bit.
    always_comb begin
        cnt_d     = cnt_q;
        bit_div_d = bit_div_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        if (fifo_pop) begin
            shift_d   = fifo_dout;
            par_d     = ^fifo_dout;
            cnt_d     = 16'd0;
            bit_div_d = eff_div(baud_div_q);
            bit_idx_d = 3'd0;
        end else if ((state_q != TX_IDLE) && bit_end) begin
            cnt_d     = 16'd0;
            bit_div_d = eff_div(baud_div_q);
            if (state_q == TX_DATA) begin
                shift_d   = shift_q >> 1;
                bit_idx_d = bit_idx_q + 3'd1;
            end
        end else if (state_q != TX_IDLE) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Outputs. txd is registered, so the line trails the state by one
    // cycle; busy_q trails the same way so busy covers the whole stop bit.
    always_comb begin
        case (state_q)
            TX_START:  txd_d = 1'b0;
            TX_DATA:   txd_d = shift_q[0];
            TX_PARITY: txd_d = par_q;
            default:   txd_d = 1'b1;
        endcase
        busy_d = (state_q != TX_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= 16'd0;
            bit_div_q <= eff_div(DIV_RESET);
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            par_q     <= 1'b0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bit_div_q <= bit_div_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
        end
    end

    assign busy      = busy_q || (state_q != TX_IDLE);
    assign txd       = txd_q;
    assign irq_empty = fifo_empty && !busy;
    assign dbg_state = state_q;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [15:0] status_w;
    logic [15:0] cnt_ext;

    assign cnt_ext = 16'(fifo_count);

    always_comb begin
        status_w              = 16'd0;
        status_w[STAT_BUSY]   = busy;
        status_w[STAT_FULL]   = fifo_full;
        status_w[STAT_EMPTY]  = fifo_empty;
        status_w[STAT_OVF]    = ovf_q;
        status_w[STAT_PAR]    = PARITY_EN;
        // A 256-deep FIFO holds one more entry than the field can show.
        status_w[15:8]        = (cnt_ext > 16'd255) ? 8'hFF : cnt_ext[7:0];
    end

    always_comb begin
        dm_dout = 64'd0;
        if (hit) begin
            case (reg_sel)
                REG_STATUS:  dm_dout = {48'd0, status_w};
                REG_BAUDDIV: dm_dout = {48'd0, baud_div_q};
                default:     dm_dout = 64'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio
//  Directed bench for uart_tx_mmio: reset values, register access,
//  cycle-exact frame shapes, back-to-back frames, FIFO overflow and
//  W1C, divider of 0, and reset in the middle of a frame.
module tb_uart_tx_mmio;
    import rvcpu_mem_pkg::*;

    localparam logic [63:0] BASE = 64'h0000_0000_1000_0000;
`ifdef UART_PARITY_EN
    localparam logic [63:0] PBIT  = 64'h10;
    localparam int          NBITS = 11;
`else
    localparam logic [63:0] PBIT  = 64'h0;
    localparam int          NBITS = 10;
`endif

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  dm_rd_ctrl;
    logic [2:0]  dm_wr_ctrl;
    logic [63:0] dm_addr;
    logic [63:0] dm_din;
    logic [63:0] dm_dout;
    logic        hit;
    logic        txd;
    logic        irq_empty;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    uart_tx_mmio dut (
        .clk        (clk),
        .rst        (rst),
        .dm_rd_ctrl (dm_rd_ctrl),
        .dm_wr_ctrl (dm_wr_ctrl),
        .dm_addr    (dm_addr),
        .dm_din     (dm_din),
        .dm_dout    (dm_dout),
        .hit        (hit),
        .txd        (txd),
        .irq_empty  (irq_empty),
        .dbg_state  (dbg_state)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Drivers (called at a negedge; writes commit on the next posedge)
    // ------------------------------------------------------------------
    task automatic bus_write(input logic [4:0] off, input logic [63:0] data, input logic [2:0] kind);
        dm_addr    = BASE + 64'(off);
        dm_din     = data;
        dm_wr_ctrl = kind;
        @(negedge clk);
        dm_wr_ctrl = ST_NONE;
        dm_addr    = 64'd0;
        dm_din     = 64'd0;
    endtask

    task automatic bus_read(input logic [63:0] addr, output logic [63:0] data, output logic h);
        dm_addr    = addr;
        dm_rd_ctrl = LD_LD;
        #1;
        data       = dm_dout;
        h          = hit;
        dm_rd_ctrl = LD_NONE;
        dm_addr    = 64'd0;
    endtask

    // Checks one frame sample-per-cycle, starting at the first start-bit sample.
    task automatic check_frame(input logic [7:0] b, input int div);
        logic [10:0] bits;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef UART_PARITY_EN
        bits[9] = ^b;
`endif
        for (int i = 0; i < NBITS; i++) begin
            for (int j = 0; j < div; j++) begin
                chk($sformatf("txd_%02h_bit%0d_c%0d", b, i, j), txd, bits[i]);
                chk($sformatf("irq_in_frame_%02h", b), irq_empty, 1'b0);
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (irq_empty !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_idle", irq_empty, 1'b1);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [63:0] rd;
    logic        h;
    int          lows;

    initial begin
        rst        = 1'b0;
        dm_rd_ctrl = LD_NONE;
        dm_wr_ctrl = ST_NONE;
        dm_addr    = 64'd0;
        dm_din     = 64'd0;
        repeat (3) @(negedge clk);
        chk("txd_in_reset", txd, 1'b1);
        rst = 1'b1;
        @(negedge clk);

        // Reset state and register map
        chk("rst_txd", txd, 1'b1);
        chk("rst_irq", irq_empty, 1'b1);
        chk("rst_state", dbg_state, 3'd0);
        chk("rst_hit_outside", hit, 1'b0);
        bus_read(BASE + 64'h08, rd, h);
        chk("rst_status", rd, 64'h0004 | PBIT);
        chk("hit_status", h, 1'b1);
        bus_read(BASE + 64'h10, rd, h);
        chk("rst_bauddiv", rd, 64'd434);
        bus_read(BASE + 64'h18, rd, h);
        chk("rsvd_read", rd, 64'd0);
        bus_read(BASE + 64'h00, rd, h);
        chk("txdata_read", rd, 64'd0);
        bus_read(BASE + 64'h0F, rd, h);
        chk("byte_off_ignored", rd, 64'h0004 | PBIT);
        bus_read(BASE + 64'h20, rd, h);
        chk("hit_above", h, 1'b0);
        chk("dout_above", rd, 64'd0);
        bus_read(BASE - 64'h1, rd, h);
        chk("hit_below", h, 1'b0);
        chk("dout_below", rd, 64'd0);

        // Reserved write is ignored
        bus_write(5'h18, 64'hFFFF, ST_SD);
        bus_read(BASE + 64'h18, rd, h);
        chk("rsvd_after_write", rd, 64'd0);

        // Single frame at BAUDDIV=4, exact start latency
        bus_write(5'h10, 64'hDEAD_0000_0000_0004, ST_SD);
        bus_read(BASE + 64'h10, rd, h);
        chk("bauddiv_4", rd, 64'd4);
        bus_write(5'h00, 64'h1234_56A5, ST_SB);
        chk("lat_edge0", txd, 1'b1);
        @(negedge clk);
        chk("lat_edge1", txd, 1'b1);
        chk("lat_irq", irq_empty, 1'b0);
        @(negedge clk);
        check_frame(8'hA5, 4);
        chk("irq_after_a5", irq_empty, 1'b1);

        // Three back-to-back frames at BAUDDIV=2
        bus_write(5'h10, 64'd2, ST_SH);
        fork
            begin
                bus_write(5'h00, 64'h07, ST_SB);
                bus_write(5'h00, 64'h03, ST_SW);
                bus_write(5'h00, 64'h5C, ST_SD);
            end
            begin
                repeat (3) @(negedge clk);
                check_frame(8'h07, 2);
                check_frame(8'h03, 2);
                check_frame(8'h5C, 2);
            end
        join
        chk("irq_after_three", irq_empty, 1'b1);

        // BAUDDIV=0 reads back 0 and runs as one cycle per bit
        bus_write(5'h10, 64'd0, ST_SD);
        bus_read(BASE + 64'h10, rd, h);
        chk("bauddiv_0", rd, 64'd0);
        bus_write(5'h00, 64'h3C, ST_SB);
        @(negedge clk);
        chk("div0_lat", txd, 1'b1);
        @(negedge clk);
        check_frame(8'h3C, 1);
        chk("irq_after_3c", irq_empty, 1'b1);

        // Overflow: one byte in flight, 16 fill the FIFO, one more drops
        bus_write(5'h10, 64'd2, ST_SD);
        bus_write(5'h00, 64'h11, ST_SB);
        for (int k = 1; k <= 17; k++) bus_write(5'h00, 64'(k), ST_SB);
        bus_read(BASE + 64'h08, rd, h);
        chk("status_overflow", rd, 64'h100B | PBIT);
        chk("irq_while_full", irq_empty, 1'b0);
        bus_write(5'h08, 64'hF7, ST_SB);
        bus_read(BASE + 64'h08, rd, h);
        chk("status_no_clear", rd, 64'h100B | PBIT);
        bus_write(5'h08, 64'h08, ST_SB);
        bus_read(BASE + 64'h08, rd, h);
        chk("status_w1c", rd, 64'h1003 | PBIT);
        wait_idle(2000);
        bus_read(BASE + 64'h08, rd, h);
        chk("status_drained", rd, 64'h0004 | PBIT);

        // Reset in the middle of data bit 3, with a byte still queued
        bus_write(5'h10, 64'd4, ST_SD);
        bus_write(5'h00, 64'h00, ST_SB);
        bus_write(5'h00, 64'h55, ST_SB);
        repeat (17) @(negedge clk);
        chk("mid_bit3_txd", txd, 1'b0);
        chk("mid_bit3_state", dbg_state, 64'(TX_DATA));
        #1;
        rst = 1'b0;
        #1;
        chk("txd_async_reset", txd, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        chk("post_rst_txd", txd, 1'b1);
        chk("post_rst_irq", irq_empty, 1'b1);
        bus_read(BASE + 64'h08, rd, h);
        chk("post_rst_status", rd, 64'h0004 | PBIT);
        bus_read(BASE + 64'h10, rd, h);
        chk("post_rst_bauddiv", rd, 64'd434);
        lows = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        chk("no_residual_frame", 64'(lows), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
